pss_tracking_controller: RTL and testbench
==========================================

// Module: pss_tracking_controller
// PURPOSE
//  Sequences the PSS detector between acquisition and tracking. In SEARCH the detector is always enabled.
//  After the first peak, the controller gates the detector to a window around each expected SSB
//  periodicity and declares lock after consecutive hits. After repeated misses it falls back to SEARCH.
//  It also maintains the per-N_id_2 peak counters and the mode word that the AXI-lite regmap reads back.
// PARAMETERS
//  PERIOD_SAMPLES  76800  expected peak-to-peak distance in sample_valid_i strobes (20 ms @ 3.84 Msps)
//  WINDOW_SAMPLES  8      half-width of tracking window; must be < PERIOD_SAMPLES/2
//  LOCK_HITS       3      consecutive in-window hits required to assert locked_o
//  MAX_MISSES      4      consecutive window misses before returning to SEARCH
// PORTS
//  clk_i              in   1   clock
//  reset_ni           in   1   asynchronous active-low reset
//  enable_i           in   1   level; 0 forces IDLE
//  clear_counters_i   in   1   pulse; zeroes the peak counters
//  sample_valid_i     in   1   one strobe per detector input sample
//  peak_valid_i       in   1   detector peak strobe, single cycle
//  peak_N_id_2_i      in   2   N_id_2 of the peak (0..2); the value 3 is ignored
//  detector_en_o      out  1   enables the PSS correlator/peak search
//  mode_o             out  2   0 = SEARCH, 1 = TRACK, 2 = IDLE
//  locked_o           out  1   lock status
//  N_id_2_o           out  2   N_id_2 being tracked
//  N_id_2_valid_o     out  1   1 in TRACK
//  peak_counter_0_o   out  32  peaks seen with N_id_2 = 0
//  peak_counter_1_o   out  32  peaks seen with N_id_2 = 1
//  peak_counter_2_o   out  32  peaks seen with N_id_2 = 2
// BEHAVIOUR
//  Reset values: state = IDLE, mode_o = 2, detector_en_o = 0, locked_o = 0, N_id_2_o = 0, N_id_2_valid_o = 0,
//   peak counters = 0, internal sample counter = 0, hits = 0, misses = 0. All outputs are registered.
//  Default latency: state and outputs update on the clock edge after the input event (1 cycle).
//  FSM:
//  - IDLE: when enable_i = 1, go to SEARCH.
//  - SEARCH: detector_en_o = 1. A peak with a valid N_id_2 latches N_id_2_o, sets cnt = 0, hits = 1,
//    misses = 0, and goes to TRACK.
//  - TRACK: cnt increments on each sample_valid_i.
//    - Window: detector_en_o = 1 only while PERIOD - WINDOW <= cnt <= PERIOD + WINDOW, bounds inclusive.
//    - Hit: an in-window peak whose N_id_2 equals N_id_2_o sets cnt = 0, misses = 0, and hits = hits + 1
//      (saturating at LOCK_HITS). When hits reaches LOCK_HITS, locked_o goes to 1.
//    - Miss: cnt reaching PERIOD + WINDOW while sample_valid_i = 1 and no hit sets cnt = WINDOW (keeping
//      the phase), hits = 0, misses = misses + 1. When misses reaches MAX_MISSES, go to SEARCH with
//      locked_o = 0 and N_id_2_valid_o = 0.
//    - Peak with a different N_id_2, or any peak outside the window: FSM unaffected; still counted.
//    - Hit on the last window sample (cnt = PERIOD + WINDOW) is a hit, not a miss.
//  - Any state with enable_i = 0: go to IDLE next cycle, clear locked_o, N_id_2_valid_o, hits, misses
//    and cnt. Peak counters retain their values.
//  Peak counters: +1 on each peak_valid_i with matching N_id_2, in any state except IDLE.
//   - Saturate at 32'hFFFFFFFF.
//   - clear_counters_i wins over a simultaneous peak; that peak is dropped.
//  Async reset mid-TRACK: everything returns to reset values immediately, with no residual window.
// CONFIGURATION
//  LOCK_LOSS_IRQ_EN defined: adds output irq_o (1 bit). It is a 1-cycle pulse on each locked_o
//   0->1 or 1->0 transition; reset value 0; a transition into IDLE that clears lock also pulses.
//  Not defined: irq_o port absent; no other change.
// STRUCTURE
//  Package pss_ctrl_pkg:
//   - state enum {IDLE, SEARCH, TRACK}
//   - mode constants MODE_SEARCH = 2'd0, MODE_TRACK = 2'd1, MODE_IDLE = 2'd2
//   - N_id_2 typedef logic [1:0]
//  cnt width = $clog2(PERIOD_SAMPLES + WINDOW_SAMPLES + 1), a localparam.
//  One sub-module, sat_counter (32-bit, inc/clr, saturating, clr priority), instantiated 3x.
// TESTING
//  1. Reset, enable_i = 1 -> mode_o = 0 and detector_en_o = 1 after 1 cycle; all counters 0.
//  2. Peak N_id_2 = 1, then peaks every 76800 samples x3 -> locked_o = 1 after the 3rd peak;
//     detector_en_o high only on cnt 76792..76808; peak_counter_1_o = 3.
//  3. Locked, no further peaks -> misses 1..4 at 76808-sample spacing, then 76800 -> after the 4th miss
//     mode_o = 0, locked_o = 0.
//  4. In TRACK, peak N_id_2 = 2 in-window -> peak_counter_2_o +1, cnt not reset, lock unchanged;
//     hit exactly at cnt = 76808 -> counted as a hit.
//  5. clear_counters_i coincident with peak -> counter reads 0; preload 32'hFFFFFFFF + peak -> stays
//     32'hFFFFFFFF.
//  6. enable_i = 0 mid-TRACK -> mode_o = 2 next cycle, counters kept; with LOCK_LOSS_IRQ_EN, one irq_o
//     pulse on lock gain and one on drop.

Source files
------------

// File: rtl/pss_ctrl_pkg.sv
// Shared types and constants for the PSS tracking controller.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package pss_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SEARCH = 2'd0;
  localparam logic [1:0] MODE_TRACK  = 2'd1;
  localparam logic [1:0] MODE_IDLE   = 2'd2;

  typedef logic [1:0] n_id_2_t;

  // Mode word as read back through the register map.
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      SEARCH:  return MODE_SEARCH;
      TRACK:   return MODE_TRACK;
      default: return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; an increment arriving at full scale is absorbed (count holds).
// Ports: clk_i/reset_ni clock and async active-low reset, clr zeroes, inc adds one, count value.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pss_tracking_controller.sv
// Sequences the PSS detector: free-running in SEARCH, windowed around the SSB period in TRACK.
// Latency: state and all registered outputs update one clock after the input event.
// Backpressure: none; peak and sample strobes are consumed every cycle they are presented.
// Ports: clk_i/reset_ni clock and async active-low reset; enable_i level enable; clear_counters_i
//   zeroes the peak counters; sample_valid_i advances the period counter; peak_valid_i/peak_N_id_2_i
//   detector peaks; detector_en_o gates the correlator; mode_o/locked_o/N_id_2_o/N_id_2_valid_o status;
//   peak_counter_{0,1,2}_o per-N_id_2 peak counts.
// Build option: define LOCK_LOSS_IRQ_EN to add irq_o, a one-cycle pulse on every locked_o change.
module pss_tracking_controller
  import pss_ctrl_pkg::*;
#(
  parameter int PERIOD_SAMPLES = 76800,
  parameter int WINDOW_SAMPLES = 8,
  parameter int LOCK_HITS      = 3,
  parameter int MAX_MISSES     = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic        clear_counters_i,
  input  logic        sample_valid_i,
  input  logic        peak_valid_i,
  input  logic [1:0]  peak_N_id_2_i,
  output logic        detector_en_o,
  output logic [1:0]  mode_o,
  output logic        locked_o,
  output logic [1:0]  N_id_2_o,
  output logic        N_id_2_valid_o,
  output logic [31:0] peak_counter_0_o,
  output logic [31:0] peak_counter_1_o,
  output logic [31:0] peak_counter_2_o
`ifdef LOCK_LOSS_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int CNT_W  = $clog2(PERIOD_SAMPLES + WINDOW_SAMPLES + 1);
  localparam int HIT_W  = $clog2(LOCK_HITS + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  localparam logic [CNT_W-1:0]  WIN_LO      = CNT_W'(PERIOD_SAMPLES - WINDOW_SAMPLES);
  localparam logic [CNT_W-1:0]  WIN_HI      = CNT_W'(PERIOD_SAMPLES + WINDOW_SAMPLES);
  // After a miss the counter restarts at WINDOW so the next window stays on the old phase.
  localparam logic [CNT_W-1:0]  WIN_RESTART = CNT_W'(WINDOW_SAMPLES);
  localparam logic [HIT_W-1:0]  HITS_LOCK   = HIT_W'(LOCK_HITS);
  localparam logic [MISS_W-1:0] MISS_LIMIT  = MISS_W'(MAX_MISSES);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [HIT_W-1:0]    hits, hits_nxt, hits_inc;
  logic [MISS_W-1:0]   misses, misses_nxt, misses_inc;
  n_id_2_t             n_id_2_nxt;
  logic                locked_nxt;
  logic                valid_nxt;

  logic peak_ok;
  logic in_window;
  logic hit;

  assign peak_ok    = peak_valid_i && (peak_N_id_2_i != 2'd3);
  assign in_window  = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign hit        = peak_ok && in_window && (peak_N_id_2_i == N_id_2_o);
  assign hits_inc   = (hits == HITS_LOCK) ? hits : hits + HIT_W'(1);
  assign misses_inc = misses + MISS_W'(1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hits_nxt   = hits;
    misses_nxt = misses;
    n_id_2_nxt = N_id_2_o;
    locked_nxt = locked_o;
    valid_nxt  = N_id_2_valid_o;

    if (!enable_i) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      hits_nxt   = '0;
      misses_nxt = '0;
      locked_nxt = 1'b0;
      valid_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SEARCH;
        end
        SEARCH: begin
          if (peak_ok) begin
            state_nxt  = TRACK;
            n_id_2_nxt = peak_N_id_2_i;
            cnt_nxt    = '0;
            hits_nxt   = HIT_W'(1);
            misses_nxt = '0;
            valid_nxt  = 1'b1;
            locked_nxt = (LOCK_HITS <= 1);
          end
        end
        TRACK: begin
          // A hit takes precedence over the miss check, so a peak on the last
          // window sample still counts as a hit.
          if (hit) begin
            cnt_nxt    = '0;
            misses_nxt = '0;
            hits_nxt   = hits_inc;
            if (hits_inc == HITS_LOCK) begin
              locked_nxt = 1'b1;
            end
          end else if (sample_valid_i) begin
            if (cnt == WIN_HI) begin
              cnt_nxt    = WIN_RESTART;
              hits_nxt   = '0;
              misses_nxt = misses_inc;
              if (misses_inc == MISS_LIMIT) begin
                state_nxt  = SEARCH;
                cnt_nxt    = '0;
                misses_nxt = '0;
                locked_nxt = 1'b0;
                valid_nxt  = 1'b0;
              end
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Outputs are derived from next-state values so that detector_en_o and
  // mode_o line up with the registered state and counter in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      hits           <= '0;
      misses         <= '0;
      N_id_2_o       <= '0;
      N_id_2_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      detector_en_o  <= 1'b0;
      mode_o         <= MODE_IDLE;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      hits           <= hits_nxt;
      misses         <= misses_nxt;
      N_id_2_o       <= n_id_2_nxt;
      N_id_2_valid_o <= valid_nxt;
      locked_o       <= locked_nxt;
      detector_en_o  <= (state_nxt == SEARCH) ||
                        ((state_nxt == TRACK) && (cnt_nxt >= WIN_LO) && (cnt_nxt <= WIN_HI));
      mode_o         <= mode_of(state_nxt);
    end
  end

`ifdef LOCK_LOSS_IRQ_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (locked_nxt != locked_o);
    end
  end
`endif

  // Peaks are counted in every non-IDLE state regardless of window or tracked N_id_2.
  logic count_en;
  assign count_en = peak_valid_i && (state != IDLE);

  sat_counter #(.WIDTH(32)) u_peak_cnt_0 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr      (clear_counters_i),
    .inc      (count_en && (peak_N_id_2_i == 2'd0)),
    .count    (peak_counter_0_o)
  );

  sat_counter #(.WIDTH(32)) u_peak_cnt_1 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr      (clear_counters_i),
    .inc      (count_en && (peak_N_id_2_i == 2'd1)),
    .count    (peak_counter_1_o)
  );

  sat_counter #(.WIDTH(32)) u_peak_cnt_2 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr      (clear_counters_i),
    .inc      (count_en && (peak_N_id_2_i == 2'd2)),
    .count    (peak_counter_2_o)
  );

endmodule

// File: tb/tb_pss_tracking_controller.sv
// Directed bench for pss_tracking_controller with a shortened period (32) and window (4),
// so the tracking window spans cnt 28..36. A narrow sat_counter instance exercises saturation.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_pss_tracking_controller;

  localparam int P  = 32;
  localparam int W  = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        clear_counters_i = 1'b0;
  logic        sample_valid_i = 1'b0;
  logic        peak_valid_i = 1'b0;
  logic [1:0]  peak_N_id_2_i = 2'd0;
  logic        detector_en_o;
  logic [1:0]  mode_o;
  logic        locked_o;
  logic [1:0]  N_id_2_o;
  logic        N_id_2_valid_o;
  logic [31:0] pc0, pc1, pc2;
`ifdef LOCK_LOSS_IRQ_EN
  logic        irq_o;
`endif

  logic       sat_clr = 1'b0;
  logic       sat_inc = 1'b0;
  logic [2:0] sat_count;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pss_tracking_controller #(
    .PERIOD_SAMPLES (P),
    .WINDOW_SAMPLES (W),
    .LOCK_HITS      (3),
    .MAX_MISSES     (4)
  ) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .enable_i         (enable_i),
    .clear_counters_i (clear_counters_i),
    .sample_valid_i   (sample_valid_i),
    .peak_valid_i     (peak_valid_i),
    .peak_N_id_2_i    (peak_N_id_2_i),
    .detector_en_o    (detector_en_o),
    .mode_o           (mode_o),
    .locked_o         (locked_o),
    .N_id_2_o         (N_id_2_o),
    .N_id_2_valid_o   (N_id_2_valid_o),
    .peak_counter_0_o (pc0),
    .peak_counter_1_o (pc1),
    .peak_counter_2_o (pc2)
`ifdef LOCK_LOSS_IRQ_EN
    ,
    .irq_o            (irq_o)
`endif
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr      (sat_clr),
    .inc      (sat_inc),
    .count    (sat_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One-cycle peak strobe, coincident with a sample strobe.
  task automatic peak(input logic [1:0] id);
    peak_valid_i  = 1'b1;
    peak_N_id_2_i = id;
    @(negedge clk_i);
    peak_valid_i  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    check_val("rst_mode", mode_o, 2);
    check_val("rst_det", detector_en_o, 0);
    check_val("rst_locked", locked_o, 0);
    check_val("rst_nid", N_id_2_o, 0);
    check_val("rst_nid_vld", N_id_2_valid_o, 0);
    check_val("rst_pc1", pc1, 0);
`ifdef LOCK_LOSS_IRQ_EN
    check_val("rst_irq", irq_o, 0);
`endif
    reset_ni = 1'b1;
    sample_valid_i = 1'b1;
    tick(1);

    // 1: enable -> SEARCH one cycle later
    enable_i = 1'b1;
    tick(1);
    check_val("t1_mode", mode_o, 0);
    check_val("t1_det", detector_en_o, 1);

    peak(2'd3);
    check_val("t1_id3_mode", mode_o, 0);
    check_val("t1_id3_pc2", pc2, 0);

    // 2: acquire on N_id_2 = 1, then two in-window hits to lock
    peak(2'd1);
    check_val("t2_mode", mode_o, 1);
    check_val("t2_nid", N_id_2_o, 1);
    check_val("t2_nid_vld", N_id_2_valid_o, 1);
    check_val("t2_det_cnt0", detector_en_o, 0);
    tick(27);
    check_val("t2_det_cnt27", detector_en_o, 0);
    tick(1);
    check_val("t2_det_cnt28", detector_en_o, 1);
    tick(4);
    peak(2'd1);
    check_val("t2_locked_h2", locked_o, 0);
    check_val("t2_det_after_hit", detector_en_o, 0);
    tick(32);
    peak(2'd1);
    check_val("t2_locked_h3", locked_o, 1);
    check_val("t2_pc1", pc1, 3);
`ifdef LOCK_LOSS_IRQ_EN
    check_val("t2_irq_gain", irq_o, 1);
`endif
    tick(1);
`ifdef LOCK_LOSS_IRQ_EN
    check_val("t2_irq_clear", irq_o, 0);
`endif

    // 4: foreign N_id_2 in-window is counted only; hit on last window sample
    tick(29);                         // cnt = 30
    peak(2'd2);                       // cnt = 31, not reset
    check_val("t4_pc2", pc2, 1);
    check_val("t4_locked", locked_o, 1);
    tick(5);                          // cnt = 36
    check_val("t4_det_cnt36", detector_en_o, 1);
    peak(2'd1);                       // hit at cnt = 36
    check_val("t4_edge_hit_det", detector_en_o, 0);
    check_val("t4_pc1", pc1, 4);
    tick(27);                         // cnt = 27 (a miss would give 31)
    check_val("t4_edge_hit_cnt", detector_en_o, 0);

    // 3: no more peaks -> four misses then SEARCH
    tick(9);                          // cnt = 36
    check_val("t3_det36", detector_en_o, 1);
    tick(1);                          // miss 1, cnt = 4
    check_val("t3_m1_det", detector_en_o, 0);
    check_val("t3_m1_locked", locked_o, 1);
    check_val("t3_m1_mode", mode_o, 1);
    tick(24);                         // cnt = 28
    check_val("t3_m1_phase", detector_en_o, 1);
    tick(9);                          // miss 2
    tick(33);                         // miss 3
    tick(32);                         // cnt = 36
    check_val("t3_pre_m4_mode", mode_o, 1);
    tick(1);                          // miss 4
    check_val("t3_m4_mode", mode_o, 0);
    check_val("t3_m4_locked", locked_o, 0);
    check_val("t3_m4_nid_vld", N_id_2_valid_o, 0);
    check_val("t3_m4_det", detector_en_o, 1);
`ifdef LOCK_LOSS_IRQ_EN
    check_val("t3_irq_drop", irq_o, 1);
`endif

    // 6: lock on N_id_2 = 0, then disable mid-TRACK
    peak(2'd0);
    tick(32);
    peak(2'd0);
    tick(32);
    peak(2'd0);
    check_val("t6_locked", locked_o, 1);
    check_val("t6_pc0", pc0, 3);
    tick(2);
    enable_i = 1'b0;
    tick(1);
    check_val("t6_mode", mode_o, 2);
    check_val("t6_det", detector_en_o, 0);
    check_val("t6_locked_off", locked_o, 0);
    check_val("t6_nid_vld", N_id_2_valid_o, 0);
    check_val("t6_pc0_kept", pc0, 3);
    check_val("t6_pc1_kept", pc1, 4);
    check_val("t6_pc2_kept", pc2, 1);
`ifdef LOCK_LOSS_IRQ_EN
    check_val("t6_irq_idle", irq_o, 1);
`endif
    peak(2'd0);
    check_val("t6_idle_nocount", pc0, 3);

    // 5: clear beats a coincident peak; FSM still acquires
    enable_i = 1'b1;
    tick(1);
    clear_counters_i = 1'b1;
    peak(2'd2);
    clear_counters_i = 1'b0;
    check_val("t5_pc0_clr", pc0, 0);
    check_val("t5_pc1_clr", pc1, 0);
    check_val("t5_pc2_clr", pc2, 0);
    check_val("t5_nid", N_id_2_o, 2);
    peak(2'd0);
    check_val("t5_pc0_after", pc0, 1);
    check_val("t5_mode_after", mode_o, 1);

    // Saturation of the counter building block
    sat_inc = 1'b1;
    tick(7);
    check_val("sat_full", sat_count, 7);
    tick(2);
    check_val("sat_hold", sat_count, 7);
    sat_clr = 1'b1;
    tick(1);
    check_val("sat_clr_wins", sat_count, 0);
    sat_clr = 1'b0;
    sat_inc = 1'b0;

    // Async reset mid-TRACK
    #2;
    reset_ni = 1'b0;
    #1;
    check_val("arst_mode", mode_o, 2);
    check_val("arst_det", detector_en_o, 0);
    check_val("arst_pc0", pc0, 0);
    check_val("arst_nid_vld", N_id_2_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
